// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift/rotate/load register with saturating shift counter and sticky lost-one flag
// Ports: clk, rst (sync, active-high), en (cycle enable), mode (3-bit op select),
//        d (parallel load), sin_l/sin_r (serial inputs), q (contents),
//        sout_l/sout_r (last bit shifted out at MSB/LSB), shift_cnt, lost_one
module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             lost_one
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic             r_sout_l, r_sout_r, r_lost, w_sout_l_nxt, w_sout_r_nxt, w_lost_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_left, w_right, w_clr, w_shift;
    always_comb begin
        w_left       = mode == 3'd1 || mode == 3'd3;
        w_right      = mode == 3'd2 || mode == 3'd4 || mode == 3'd6;
        w_clr        = mode == 3'd5 || mode == 3'd7;
        w_shift      = w_left || w_right;
        w_q_nxt      = mode == 3'd1 ? {r_q[WIDTH-2:0], sin_l} :
                       mode == 3'd2 ? {sin_r, r_q[WIDTH-1:1]} :
                       mode == 3'd3 ? {r_q[WIDTH-2:0], r_q[WIDTH-1]} :
                       mode == 3'd4 ? {r_q[0], r_q[WIDTH-1:1]} :
                       mode == 3'd5 ? d :
                       mode == 3'd6 ? {r_q[WIDTH-1], r_q[WIDTH-1:1]} :
                       mode == 3'd7 ? '0 : r_q;
        w_sout_l_nxt = w_left ? r_q[WIDTH-1] : w_clr ? 1'b0 : r_sout_l;
        w_sout_r_nxt = w_right ? r_q[0] : w_clr ? 1'b0 : r_sout_r;
        // only non-rotate shifts can lose a bit
        w_lost_nxt   = w_clr ? 1'b0 :
                       mode == 3'd1 ? r_lost | r_q[WIDTH-1] :
                       (mode == 3'd2 || mode == 3'd6) ? r_lost | r_q[0] : r_lost;
        w_cnt_nxt    = w_clr ? '0 : (w_shift && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= RST_VAL;
            r_sout_l <= 1'b0;
            r_sout_r <= 1'b0;
            r_cnt    <= '0;
            r_lost   <= 1'b0;
        end else if (en) begin
            r_q      <= w_q_nxt;
            r_sout_l <= w_sout_l_nxt;
            r_sout_r <= w_sout_r_nxt;
            r_cnt    <= w_cnt_nxt;
            r_lost   <= w_lost_nxt;
        end
    end
    assign q         = r_q;
    assign sout_l    = r_sout_l;
    assign sout_r    = r_sout_r;
    assign shift_cnt = r_cnt;
    assign lost_one  = r_lost;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: table vectors, scripted corner sequences and random traffic against a reference model
module tb_univ_shift_reg;
    typedef struct packed {
        logic [7:0] q;
        logic       sl;
        logic       sr;
        logic [3:0] cnt;
        logic       lost;
    } exp_t;
    typedef struct packed {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin_l;
        logic       sin_r;
        exp_t       ex;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst, en, sin_l, sin_r;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q;
    logic       sout_l, sout_r, lost_one;
    logic [3:0] shift_cnt;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    vec_t       tbl[$];
    exp_t       m;
    always #5 clk = ~clk;
    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
        .q(q), .sout_l(sout_l), .sout_r(sout_r), .shift_cnt(shift_cnt), .lost_one(lost_one)
    );
    task automatic model(input logic r, input logic e, input logic [2:0] md, input logic [7:0] dd,
                         input logic sl, input logic sr);
        exp_t o;
        o = m;
        if (r) begin
            m = '{q: 8'hA5, sl: 1'b0, sr: 1'b0, cnt: 4'd0, lost: 1'b0};
        end else if (e) begin
            case (md)
                3'd1: begin m.q = {o.q[6:0], sl};     m.sl = o.q[7]; m.lost = o.lost | o.q[7]; end
                3'd2: begin m.q = {sr, o.q[7:1]};     m.sr = o.q[0]; m.lost = o.lost | o.q[0]; end
                3'd3: begin m.q = {o.q[6:0], o.q[7]}; m.sl = o.q[7]; end
                3'd4: begin m.q = {o.q[0], o.q[7:1]}; m.sr = o.q[0]; end
                3'd5: m = '{q: dd, sl: 1'b0, sr: 1'b0, cnt: 4'd0, lost: 1'b0};
                3'd6: begin m.q = {o.q[7], o.q[7:1]}; m.sr = o.q[0]; m.lost = o.lost | o.q[0]; end
                3'd7: m = '{q: 8'h00, sl: 1'b0, sr: 1'b0, cnt: 4'd0, lost: 1'b0};
                default: ;
            endcase
            if (md inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6} && o.cnt != 4'd15) m.cnt = o.cnt + 4'd1;
        end
    endtask
    task automatic step(input logic r, input logic e, input logic [2:0] md, input logic [7:0] dd,
                        input logic sl, input logic sr, input bit use_ex, input exp_t ex, input int tag);
        exp_t got, want;
        rst = r; en = e; mode = md; d = dd; sin_l = sl; sin_r = sr;
        model(r, e, md, dd, sl, sr);
        sb.push_back(use_ex ? ex : m);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        got  = '{q: q, sl: sout_l, sr: sout_r, cnt: shift_cnt, lost: lost_one};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step%0d: got q=%h sl=%b sr=%b cnt=%0d lost=%b, expected q=%h sl=%b sr=%b cnt=%0d lost=%b",
                     tag, got.q, got.sl, got.sr, got.cnt, got.lost, want.q, want.sl, want.sr, want.cnt, want.lost);
        end
    endtask
    function automatic vec_t v(input logic r, input logic e, input logic [2:0] md, input logic [7:0] dd,
                               input logic sl, input logic sr, input logic [7:0] eq, input logic esl,
                               input logic esr, input logic [3:0] ec, input logic el);
        return '{rst: r, en: e, mode: md, d: dd, sin_l: sl, sin_r: sr,
                 ex: '{q: eq, sl: esl, sr: esr, cnt: ec, lost: el}};
    endfunction
    initial begin
        m = '0;
        rst = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'hA5, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 8'h00, 0, 0, 8'hA5, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 5, 8'h81, 0, 0, 8'h81, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 8'h00, 0, 0, 8'h02, 1, 0, 1, 1));
        tbl.push_back(v(0, 1, 5, 8'h81, 0, 0, 8'h81, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 6, 8'h00, 0, 1, 8'hC0, 0, 1, 1, 1));
        tbl.push_back(v(0, 1, 6, 8'h00, 0, 1, 8'hE0, 0, 0, 2, 1));
        tbl.push_back(v(0, 1, 6, 8'h00, 0, 1, 8'hF0, 0, 0, 3, 1));
        tbl.push_back(v(0, 1, 5, 8'h96, 0, 0, 8'h96, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 3, 8'h00, 0, 0, 8'h2D, 1, 0, 1, 0));
        tbl.push_back(v(0, 1, 3, 8'h00, 0, 0, 8'h5A, 0, 0, 2, 0));
        tbl.push_back(v(0, 1, 3, 8'h00, 0, 0, 8'hB4, 0, 0, 3, 0));
        tbl.push_back(v(0, 1, 3, 8'h00, 0, 0, 8'h69, 1, 0, 4, 0));
        tbl.push_back(v(0, 1, 3, 8'h00, 0, 0, 8'hD2, 0, 0, 5, 0));
        tbl.push_back(v(0, 1, 3, 8'h00, 0, 0, 8'hA5, 1, 0, 6, 0));
        tbl.push_back(v(0, 1, 3, 8'h00, 0, 0, 8'h4B, 1, 0, 7, 0));
        tbl.push_back(v(0, 1, 3, 8'h00, 0, 0, 8'h96, 0, 0, 8, 0));
        tbl.push_back(v(0, 0, 1, 8'h00, 1, 0, 8'h96, 0, 0, 8, 0));
        tbl.push_back(v(1, 1, 5, 8'hFF, 0, 0, 8'hA5, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 5, 8'h03, 0, 0, 8'h03, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 2, 8'h00, 0, 1, 8'h81, 0, 1, 1, 1));
        tbl.push_back(v(0, 1, 4, 8'h00, 0, 0, 8'hC0, 0, 1, 2, 1));
        tbl.push_back(v(0, 1, 0, 8'hFF, 1, 1, 8'hC0, 0, 1, 2, 1));
        tbl.push_back(v(0, 1, 7, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 8'h00, 1, 0, 8'h01, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 4, 8'h00, 0, 0, 8'h80, 0, 1, 2, 0));
        @(posedge clk);
        #1;
        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sin_l, tbl[i].sin_r, 1'b1, tbl[i].ex, i);
        // counter saturation: 20 logical right shifts after a load of all ones
        step(0, 1, 5, 8'hFF, 0, 0, 1'b0, '0, 100);
        for (int i = 0; i < 20; i++) step(0, 1, 2, 8'h00, 0, 0, 1'b0, '0, 101 + i);
        checks++;
        if (q !== 8'h00 || shift_cnt !== 4'd15 || lost_one !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got q=%h cnt=%0d lost=%b, expected q=00 cnt=15 lost=1", q, shift_cnt, lost_one);
        end
        step(0, 1, 7, 8'h00, 0, 0, 1'b1, '{q: 8'h00, sl: 1'b0, sr: 1'b0, cnt: 4'd0, lost: 1'b0}, 130);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, 1000 + i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
